// File: rtl/exe_hazard_controller.sv
// Execute-stage hazard control: EX/MEM/WB slot tracking, forwarding selects, load-use stalls, branch flushes; forwarding via EXE_FORWARD_EN.
// Latency: stall/flush_id/bubble_ex combinational from slots and decode inputs; fwd_*_sel registered on the edge that moves decode into EX.
// Backpressure: stall holds PC and IF/ID with a bubble into EX; ex_redirect overrides stall because decode is wrong-path.
module exe_hazard_controller #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_writes,
   input  logic                  id_is_load,
   input  logic                  ex_redirect,
   output logic                  stall,
   output logic                  flush_id,
   output logic                  bubble_ex,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dest;
      logic                  writes;
      logic                  is_load;
   } slot_t;

   slot_t ex_slot;
   slot_t mem_slot;

   // Register 0 is hard-wired zero, so it never creates a dependency.
   function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] r,
                                       input logic uses);
      return s.valid && s.writes && (s.dest == r) && (r != '0) && uses;
   endfunction

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic hazard;

   assign ex_hit_a  = slot_match(ex_slot,  id_rs, id_uses_rs);
   assign ex_hit_b  = slot_match(ex_slot,  id_rt, id_uses_rt);
   assign mem_hit_a = slot_match(mem_slot, id_rs, id_uses_rs);
   assign mem_hit_b = slot_match(mem_slot, id_rt, id_uses_rt);

`ifdef EXE_FORWARD_EN
   logic [1:0] sel_a_nxt, sel_b_nxt;

   // Only a load still in EX cannot be forwarded in time.
   assign hazard = id_valid && ex_slot.is_load && (ex_hit_a || ex_hit_b);

   // The EX-slot producer is younger than the MEM-slot one, so it wins.
   assign sel_a_nxt = ex_hit_a ? 2'd1 : (mem_hit_a ? 2'd2 : 2'd0);
   assign sel_b_nxt = ex_hit_b ? 2'd1 : (mem_hit_b ? 2'd2 : 2'd0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fwd_a_sel <= 2'd0;
         fwd_b_sel <= 2'd0;
      end else if (bubble_ex || !id_valid) begin
         fwd_a_sel <= 2'd0;
         fwd_b_sel <= 2'd0;
      end else begin
         fwd_a_sel <= sel_a_nxt;
         fwd_b_sel <= sel_b_nxt;
      end
   end
`else
   slot_t wb_slot;
   logic  wb_hit_a, wb_hit_b;

   // Regfile writes are not readable in the same cycle, so WB still blocks.
   assign wb_hit_a = slot_match(wb_slot, id_rs, id_uses_rs);
   assign wb_hit_b = slot_match(wb_slot, id_rt, id_uses_rt);
   assign hazard   = id_valid && (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b ||
                                  wb_hit_a || wb_hit_b);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) wb_slot <= '0;
      else        wb_slot <= mem_slot;
   end

   assign fwd_a_sel = 2'd0;
   assign fwd_b_sel = 2'd0;
`endif

   assign flush_id  = ex_redirect;
   assign stall     = hazard && !ex_redirect;
   assign bubble_ex = hazard || ex_redirect;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_slot  <= '0;
         mem_slot <= '0;
      end else begin
         mem_slot <= ex_slot;
         if (bubble_ex || !id_valid) ex_slot <= '0;
         else                        ex_slot <= '{1'b1, id_dest, id_writes, id_is_load};
      end
   end

endmodule

// File: tb/tb_exe_hazard_controller.sv
// Directed vector bench for exe_hazard_controller; expectations switch with EXE_FORWARD_EN.
module tb_exe_hazard_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       id_valid, id_uses_rs, id_uses_rt, id_writes, id_is_load, ex_redirect;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       stall, flush_id, bubble_ex;
   logic [1:0] fwd_a_sel, fwd_b_sel;

   int n_vec  = 0;
   int n_miss = 0;

   exe_hazard_controller #(.REG_ADDR_W(5)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
      .id_writes(id_writes), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall(stall), .flush_id(flush_id), .bubble_ex(bubble_ex),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       v;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] dest;
      logic       wr, ld, rd;
      logic       st, fl, bu;
      logic [1:0] fa, fb;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int v, rs, urs, rt, urt, dest, wr, ld, rd,
                               input int st, fl, bu, fa, fb);
      vec_t t;
      t.v = v[0]; t.rs = rs[4:0]; t.urs = urs[0]; t.rt = rt[4:0]; t.urt = urt[0];
      t.dest = dest[4:0]; t.wr = wr[0]; t.ld = ld[0]; t.rd = rd[0];
      t.st = st[0]; t.fl = fl[0]; t.bu = bu[0]; t.fa = fa[1:0]; t.fb = fb[1:0];
      return t;
   endfunction

   task automatic drive(input vec_t t);
      id_valid = t.v; id_rs = t.rs; id_uses_rs = t.urs; id_rt = t.rt; id_uses_rt = t.urt;
      id_dest = t.dest; id_writes = t.wr; id_is_load = t.ld; ex_redirect = t.rd;
   endtask

   task automatic cmp(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, exp);
      end
   endtask

   task automatic check(input int idx, input logic es, ef, eb, input logic [1:0] efa, efb);
      n_vec++;
      cmp("stall",     idx, {1'b0, stall},     {1'b0, es});
      cmp("flush_id",  idx, {1'b0, flush_id},  {1'b0, ef});
      cmp("bubble_ex", idx, {1'b0, bubble_ex}, {1'b0, eb});
      cmp("fwd_a_sel", idx, fwd_a_sel, efa);
      cmp("fwd_b_sel", idx, fwd_b_sel, efb);
   endtask

   initial begin
      vec_t idle;
      idle = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
`ifdef EXE_FORWARD_EN
      //              v rs u rt u  d w l r   st fl bu fa fb
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 0,0,0,0,0)); // sub r5 <- r3
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,1,0)); // sub in EX: EX/MEM forward
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 3,1, 8,1, 7,1,0,0, 0,0,0,0,0)); // use r3 after nop
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,2,0));
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3 again
      tbl.push_back(mk(1, 3,1,10,1, 9,1,0,0, 0,0,0,0,0)); // use r3
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,1,0)); // younger producer wins
      tbl.push_back(mk(1, 1,1, 0,0, 4,1,1,0, 0,0,0,0,0)); // lw r4
      tbl.push_back(mk(1, 5,1, 4,1, 6,1,0,0, 1,0,1,0,0)); // add rt=r4: load-use
      tbl.push_back(mk(1, 5,1, 4,1, 6,1,0,0, 0,0,0,0,0)); // held add, stall cleared
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,2));
      tbl.push_back(mk(1, 1,1, 0,0, 0,1,1,0, 0,0,0,0,0)); // lw r0
      tbl.push_back(mk(1, 5,1, 0,1, 6,1,0,0, 0,0,0,0,0)); // reads r0: no hazard
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(1, 3,0, 2,1, 8,1,0,0, 0,0,0,0,0)); // rs=r3 but unused
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 4,1,1,0, 0,0,0,0,0)); // lw r4
      tbl.push_back(mk(1, 4,0, 2,1, 6,1,0,0, 0,0,0,0,0)); // rs=r4 unused: no stall
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 4,1,1,0, 0,0,0,0,0)); // lw r4
      tbl.push_back(mk(1, 5,1, 4,1, 6,1,0,1, 0,1,1,0,0)); // load-use + redirect
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0)); // EX bubble
      tbl.push_back(mk(1, 1,1, 0,0, 4,1,1,0, 0,0,0,0,0)); // lw r4
      tbl.push_back(mk(1, 4,1, 0,0, 5,1,1,0, 1,0,1,0,0)); // lw r5 <- r4
      tbl.push_back(mk(1, 4,1, 0,0, 5,1,1,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 5,1, 2,1, 6,1,0,0, 1,0,1,2,0)); // add <- r5
      tbl.push_back(mk(1, 5,1, 2,1, 6,1,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,2,0));
`else
      //              v rs u rt u  d w l r   st fl bu fa fb
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 1,0,1,0,0)); // use r3: EX
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 1,0,1,0,0)); // MEM
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 1,0,1,0,0)); // WB
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 0,0,0,0,0)); // enters EX on 4th edge
      tbl.push_back(mk(1, 5,1, 1,1, 7,1,0,0, 1,0,1,0,0)); // reader of r5
      tbl.push_back(mk(1, 5,1, 1,1, 7,1,0,0, 1,0,1,0,0));
      tbl.push_back(mk(1, 5,1, 1,1, 7,1,0,0, 1,0,1,0,0));
      tbl.push_back(mk(1, 5,1, 1,1, 7,1,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 1,1, 2,1, 0,1,0,0, 0,0,0,0,0)); // add r0
      tbl.push_back(mk(1, 0,1, 0,1, 8,1,0,0, 0,0,0,0,0)); // reads r0
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(1, 3,0, 1,1, 9,1,0,0, 0,0,0,0,0)); // rs=r3 unused
      tbl.push_back(mk(1, 1,1, 2,1, 3,1,0,0, 0,0,0,0,0)); // add r3
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,1, 0,1,1,0,0)); // hazard + redirect
      tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 1,0,1,0,0)); // producer only in WB
      tbl.push_back(mk(1, 3,1, 6,1, 5,1,0,0, 0,0,0,0,0));
`endif
      tbl.push_back(mk(1, 1,1, 0,0, 4,1,1,0, 0,0,0,0,0)); // lw r4, ahead of the reset test

      reset = 1'b0;
      drive(idle);
      repeat (2) @(posedge clock);
      #1 check(-1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      #1 reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1 check(i, tbl[i].st, tbl[i].fl, tbl[i].bu, tbl[i].fa, tbl[i].fb);
         @(posedge clock);
         #1;
      end

      // Reset asserted asynchronously in the middle of a stall cycle.
      drive(mk(1, 5,1, 4,1, 6,1,0,0, 0,0,0,0,0));
      #1 check(100, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
      #2 reset = 1'b0;
      #1 check(101, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      #2 drive(idle);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clock);
         #1 check(102 + k, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/exe_hazard_controller.md
Name: exe_hazard_controller

Overview:
- Sequences the execute stage of the 5-stage MIPS pipeline.
- Tracks in-flight destination registers in the EX, MEM and WB slots.
- Outputs: registered forwarding selects for the stage_exe data_a/data_b operand muxes, load-use stalls, and IF/ID flushes on a taken branch.
- Sits between the decode stage and stage_exe and drives the PC and IF/ID hold and bubble controls.

Parameters:
REG_ADDR_W, 5, register-address width; register 0 is hard-wired zero and is never a hazard source.

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode holds a real instruction
id_rs  in  REG_ADDR_W  source A register of decode instruction
id_rt  in  REG_ADDR_W  source B register of decode instruction
id_uses_rs  in  1  decode instruction reads id_rs
id_uses_rt  in  1  decode instruction reads id_rt
id_dest  in  REG_ADDR_W  destination register of decode instruction
id_writes  in  1  decode instruction writes id_dest
id_is_load  in  1  decode instruction is a load; result available after MEM
ex_redirect  in  1  branch in EX taken (stage_exe use_npc == 0 with is_branch)
stall  out  1  hold PC and IF/ID register
flush_id  out  1  squash IF/ID contents
bubble_ex  out  1  load NOP into ID/EX this edge
fwd_a_sel  out  2  data_a source for instruction now in EX: 0 regfile, 1 EX/MEM out, 2 MEM/WB result
fwd_b_sel  out  2  same for data_b

Behaviour:
- Reset (reset == 0, async): EX, MEM and WB slots invalid; fwd_a_sel = fwd_b_sel = 0; stall = flush_id = bubble_ex = 0.
- Slot record: {valid, dest, writes, is_load}.
- A slot "matches" source r when all of these hold: valid, writes, dest == r, r != 0, and the corresponding uses_* bit is set.
- Slot shift, every rising edge: WB <= MEM; MEM <= EX; EX <= decode record, or an invalid bubble when bubble_ex = 1 or id_valid = 0.
- Load-use hazard: the EX slot is_load = 1 and matches id_rs or id_rt -> stall = 1 and bubble_ex = 1 for exactly one cycle. The next cycle the load is in MEM and forwarding resolves the dependency.
- Redirect (combinational): ex_redirect = 1 -> flush_id = 1 and bubble_ex = 1, stall = 0. Redirect overrides stall, because the decode instruction is wrong-path.
- Forward selects are registered and computed on the edge that moves the decode instruction into EX:
  - EX-slot match -> 1;
  - else MEM-slot match -> 2;
  - else 0.
  - The younger producer wins when both slots match.
- When the EX slot receives a bubble, both selects register 0.
- All outputs other than fwd_*_sel are combinational from the slots and the current inputs; there is no extra latency.
- Matches with id_uses_* = 0 are ignored.
- A match on register 0 is never a hazard and is never forwarded.
- Back-to-back loads feeding each other stall once per dependent pair.
- A stall cycle that coincides with the load moving to MEM clears on the next edge; no stall lasts longer than 1 cycle with forwarding enabled.

Optional Feature:
- Macro: EXE_FORWARD_EN.
- Defined: forwarding as above; stalls occur only on load-use.
- Undefined:
  - fwd_a_sel and fwd_b_sel are constant 0.
  - stall = bubble_ex = 1 while any of the EX, MEM or WB slots matches id_rs or id_rt. The regfile write is not readable in the same cycle, so WB is included.
  - A dependency on the immediately preceding ALU instruction therefore stalls 3 cycles.
  - Redirect still overrides stall.

Test Plan:
- Forward from EX/MEM: add r3 <- r1, r2 (writes r3), then sub reading rs = r3 -> no stall; fwd_a_sel = 1 the cycle sub is in EX, fwd_b_sel = 0.
- Forward from MEM/WB, younger-producer priority:
  - add r3, then nop, then use r3 -> fwd_a_sel = 2;
  - add r3, add r3, use r3 -> fwd_a_sel = 1.
- Load-use: lw r4, then add reading rt = r4 -> stall = 1 and bubble_ex = 1 for 1 cycle, then fwd_b_sel = 2 with add in EX. An identical sequence with dest r0 -> no stall, fwd 0.
- Redirect priority: a load-use condition and ex_redirect = 1 in the same cycle -> flush_id = 1, bubble_ex = 1, stall = 0; next cycle the EX slot is invalid and fwd selects are 0.
- Reset mid-stall: drive reset = 0 asynchronously while stall = 1 -> all outputs 0 immediately. After release, with id_valid = 0, stall stays 0.
- EXE_FORWARD_EN undefined: add r3, then use r3 -> stall high for 3 consecutive cycles, fwd selects 0 throughout, and the dependent instruction enters EX on the 4th edge.
